// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one 32-bit word
// per line. Sits between the CPU load/store port and mainmem, speaking the
// mem_pkg request/response handshake on both sides.

package mem_pkg;
    localparam int BLOCK_SIZE = 32;

    typedef struct packed {
        logic                  Valid;
        logic                  Write;
        logic [31:0]           Addr;
        logic [BLOCK_SIZE-1:0] Wdata;
    } mem_input_t;

    typedef struct packed {
        logic                  Ready;
        logic [BLOCK_SIZE-1:0] Rdata;
    } mem_output_t;
endpackage

module dm_cache
    import mem_pkg::*;
#(
    parameter int NUM_LINES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  mem_input_t  cpu_i,
    output mem_output_t cpu_o,
    output mem_input_t  mem_o,
    input  mem_output_t mem_i
);

    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        WB_GAP,
        ALLOCATE,
        AL_GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_LINES];
    logic [BLOCK_SIZE-1:0] data_q [NUM_LINES];

    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             accept;
    logic             unused_addr_bits;

    // Byte offset is irrelevant for a word-per-line cache.
    assign unused_addr_bits = ^cpu_i.Addr[1:0];

    assign idx     = cpu_i.Addr[IDX+1:2];
    assign req_tag = cpu_i.Addr[31:IDX+2];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
    // Holding off while the ack is visible keeps a held request from being
    // serviced twice.
    assign accept  = (state == IDLE) && cpu_i.Valid && !cpu_o.Ready;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore memory-side request.
    always_comb begin
        state_next = state;
        mem_o      = '0;
        case (state)
            IDLE: begin
                if (accept && !hit) begin
                    state_next = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_o.Valid = 1'b1;
                mem_o.Write = 1'b1;
                mem_o.Addr  = {tag_q[idx], idx, 2'b00};
                mem_o.Wdata = data_q[idx];
                if (mem_i.Ready) begin
                    state_next = WB_GAP;
                end
            end
            WB_GAP: begin
                // Swallows the duplicate Ready from the last Valid cycle.
                state_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_o.Valid = 1'b1;
                mem_o.Addr  = {req_tag, idx, 2'b00};
                if (mem_i.Ready) begin
                    state_next = AL_GAP;
                end
            end
            AL_GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Valid/dirty bookkeeping and the registered CPU acknowledge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            cpu_o   <= '0;
        end else begin
            cpu_o.Ready <= 1'b0;
            cpu_o.Rdata <= '0;
            case (state)
                IDLE: begin
                    if (accept && hit) begin
                        cpu_o.Ready <= 1'b1;
                        if (cpu_i.Write) begin
                            dirty_q[idx] <= 1'b1;
                        end else begin
                            cpu_o.Rdata <= data_q[idx];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_i.Ready) begin
                        dirty_q[idx] <= 1'b0;
                    end
                end
                ALLOCATE: begin
                    if (mem_i.Ready) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data storage; no reset since valid gates their use.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && accept && hit && cpu_i.Write) begin
            data_q[idx] <= cpu_i.Wdata;
        end else if (state == ALLOCATE && mem_i.Ready) begin
            data_q[idx] <= mem_i.Rdata;
            tag_q[idx]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// Directed testbench for dm_cache with a behavioural mainmem that answers
// one cycle after every cycle it samples Valid.

module tb_dm_cache;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    mem_input_t  cpu_i;
    mem_output_t cpu_o;
    mem_input_t  mem_o;
    mem_output_t mem_i;

    int checks = 0;
    int errors = 0;

    // mainmem model storage, indexed by word address bits [13:2]
    logic [31:0] mem_words [0:4095];
    logic        pl_en;
    logic [31:0] pl_addr;
    logic [31:0] pl_data;

    // per-cycle trace of the last transaction, index k = cycles after accept
    logic        tr_mv [0:31];
    logic        tr_mw [0:31];
    logic [31:0] tr_ma [0:31];
    logic [31:0] tr_md [0:31];
    logic        tr_mr [0:31];

    int          lat;
    logic [31:0] rd;

    always #5 clk = ~clk;

    dm_cache #(.NUM_LINES(256)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cpu_i (cpu_i),
        .cpu_o (cpu_o),
        .mem_o (mem_o),
        .mem_i (mem_i)
    );

    // Behavioural mainmem with a preload port for the bench.
    always @(posedge clk) begin
        mem_i.Ready <= mem_o.Valid;
        mem_i.Rdata <= mem_words[mem_o.Addr[13:2]];
        if (mem_o.Valid && mem_o.Write) begin
            mem_words[mem_o.Addr[13:2]] <= mem_o.Wdata;
        end else if (pl_en) begin
            mem_words[pl_addr[13:2]] <= pl_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        step();
        pl_en   = 1'b0;
    endtask

    // Drives one request, records the memory-side trace, returns the ack
    // latency (-1 if no ack within the budget) and the ack data.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output int l, output logic [31:0] r);
        for (int k = 0; k < 32; k++) begin
            tr_mv[k] = 1'b0; tr_mw[k] = 1'b0; tr_ma[k] = '0; tr_md[k] = '0; tr_mr[k] = 1'b0;
        end
        cpu_i.Valid = 1'b1;
        cpu_i.Write = wr;
        cpu_i.Addr  = addr;
        cpu_i.Wdata = wd;
        l = -1;
        r = '0;
        for (int k = 1; k <= 20; k++) begin
            step();
            tr_mv[k] = mem_o.Valid;
            tr_mw[k] = mem_o.Write;
            tr_ma[k] = mem_o.Addr;
            tr_md[k] = mem_o.Wdata;
            tr_mr[k] = mem_i.Ready;
            if (cpu_o.Ready) begin
                l = k;
                r = cpu_o.Rdata;
                break;
            end
        end
        cpu_i = '0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        cpu_i = '0;
        pl_en = 1'b0;
        step();
        preload(32'h0001_0000, 32'hDEAD_BEEF);
        preload(32'h0001_0400, 32'hA5A5_0400);
        preload(32'h0001_0010, 32'h1111_0010);
        preload(32'h0001_0410, 32'h2222_0410);
        preload(32'h0001_0800, 32'h0BAD_0800);
        checks++;
        if (cpu_o.Ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %0b want 0", cpu_o.Ready);
        end
        checks++;
        if (cpu_o.Rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", cpu_o.Rdata);
        end
        checks++;
        if (mem_o !== '0) begin
            errors++; $display("FAIL reset_mem_o got %h want 0", mem_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_miss();
        do_req(1'b0, 32'h0001_0000, '0, lat, rd);
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL rdmiss_lat got %0d want 5", lat);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rdmiss_data got %h want deadbeef", rd);
        end
        checks++;
        if (tr_mv[1] !== 1'b1 || tr_mw[1] !== 1'b0 || tr_ma[1] !== 32'h0001_0000) begin
            errors++; $display("FAIL rdmiss_memreq got v%0b w%0b a%h want v1 w0 a00010000",
                               tr_mv[1], tr_mw[1], tr_ma[1]);
        end
        step();
        checks++;
        if (cpu_o.Ready !== 1'b0) begin
            errors++; $display("FAIL ack_pulse got %0b want 0", cpu_o.Ready);
        end
        do_req(1'b0, 32'h0001_0000, '0, lat, rd);
        checks++;
        if (lat !== 1 || rd !== 32'hDEAD_BEEF || tr_mv[1] !== 1'b0) begin
            errors++; $display("FAIL rdhit got lat%0d d%h mv%0b want lat1 ddeadbeef mv0",
                               lat, rd, tr_mv[1]);
        end
        step();
    endtask

    task automatic test_write_hit();
        do_req(1'b1, 32'h0001_0000, 32'h1234_5678, lat, rd);
        checks++;
        if (lat !== 1 || rd !== 32'h0 || tr_mv[1] !== 1'b0) begin
            errors++; $display("FAIL wrhit got lat%0d d%h mv%0b want lat1 d0 mv0", lat, rd, tr_mv[1]);
        end
        step();
        do_req(1'b0, 32'h0001_0000, '0, lat, rd);
        checks++;
        if (lat !== 1 || rd !== 32'h1234_5678) begin
            errors++; $display("FAIL wrhit_readback got lat%0d d%h want lat1 d12345678", lat, rd);
        end
        step();
    endtask

    task automatic test_dirty_eviction();
        int nrd;
        do_req(1'b0, 32'h0001_0400, '0, lat, rd);
        checks++;
        if (lat !== 8 || rd !== 32'hA5A5_0400) begin
            errors++; $display("FAIL evict got lat%0d d%h want lat8 da5a50400", lat, rd);
        end
        checks++;
        if (tr_mv[1] !== 1'b1 || tr_mw[1] !== 1'b1 || tr_ma[1] !== 32'h0001_0000 ||
            tr_md[1] !== 32'h1234_5678) begin
            errors++; $display("FAIL evict_wb got v%0b w%0b a%h d%h want v1 w1 a00010000 d12345678",
                               tr_mv[1], tr_mw[1], tr_ma[1], tr_md[1]);
        end
        checks++;
        if (tr_mv[3] !== 1'b0 || tr_mr[3] !== 1'b1) begin
            errors++; $display("FAIL wb_gap got mv%0b mr%0b want mv0 mr1", tr_mv[3], tr_mr[3]);
        end
        nrd = 0;
        for (int k = 1; k <= 8; k++) begin
            if (tr_mv[k] && !tr_mw[k]) nrd++;
        end
        checks++;
        if (nrd !== 2 || tr_mv[4] !== 1'b1 || tr_mw[4] !== 1'b0 || tr_ma[4] !== 32'h0001_0400 ||
            tr_mr[5] !== 1'b1 || tr_mv[6] !== 1'b0) begin
            errors++; $display("FAIL refill_window got nrd%0d a4=%h mr5=%0b mv6=%0b want 2 00010400 1 0",
                               nrd, tr_ma[4], tr_mr[5], tr_mv[6]);
        end
        checks++;
        if (mem_words[32'h0001_0000 >> 2 & 32'hFFF] !== 32'h1234_5678) begin
            errors++; $display("FAIL evict_memword got %h want 12345678",
                               mem_words[32'h0001_0000 >> 2 & 32'hFFF]);
        end
        step();
        do_req(1'b0, 32'h0001_0000, '0, lat, rd);
        checks++;
        if (lat !== 5 || rd !== 32'h1234_5678) begin
            errors++; $display("FAIL clean_refetch got lat%0d d%h want lat5 d12345678", lat, rd);
        end
        step();
    endtask

    task automatic test_write_miss();
        do_req(1'b1, 32'h0001_0010, 32'hCAFE_F00D, lat, rd);
        checks++;
        if (lat !== 5 || rd !== 32'h0 || tr_mv[1] !== 1'b1 || tr_mw[1] !== 1'b0 ||
            tr_ma[1] !== 32'h0001_0010) begin
            errors++; $display("FAIL wrmiss got lat%0d d%h v%0b w%0b a%h want lat5 d0 v1 w0 a00010010",
                               lat, rd, tr_mv[1], tr_mw[1], tr_ma[1]);
        end
        step();
        do_req(1'b0, 32'h0001_0010, '0, lat, rd);
        checks++;
        if (lat !== 1 || rd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wrmiss_readback got lat%0d d%h want lat1 dcafef00d", lat, rd);
        end
        step();
        do_req(1'b0, 32'h0001_0410, '0, lat, rd);
        checks++;
        if (lat !== 8 || rd !== 32'h2222_0410 || tr_mw[1] !== 1'b1 ||
            tr_ma[1] !== 32'h0001_0010 || tr_md[1] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wrmiss_evict got lat%0d d%h w%0b a%h wd%h want 8 22220410 1 00010010 cafef00d",
                               lat, rd, tr_mw[1], tr_ma[1], tr_md[1]);
        end
        checks++;
        if (mem_words[32'h0001_0010 >> 2 & 32'hFFF] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL wrmiss_memword got %h want cafef00d",
                               mem_words[32'h0001_0010 >> 2 & 32'hFFF]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        cpu_i.Valid = 1'b1;
        cpu_i.Write = 1'b0;
        cpu_i.Addr  = 32'h0001_0410;
        cpu_i.Wdata = '0;
        step();
        checks++;
        if (cpu_o.Ready !== 1'b1 || cpu_o.Rdata !== 32'h2222_0410) begin
            errors++; $display("FAIL b2b_first got r%0b d%h want r1 d22220410", cpu_o.Ready, cpu_o.Rdata);
        end
        cpu_i.Addr = 32'h0001_0000;
        step();
        checks++;
        if (cpu_o.Ready !== 1'b0) begin
            errors++; $display("FAIL b2b_gap got r%0b want r0", cpu_o.Ready);
        end
        step();
        checks++;
        if (cpu_o.Ready !== 1'b1 || cpu_o.Rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL b2b_second got r%0b d%h want r1 d12345678", cpu_o.Ready, cpu_o.Rdata);
        end
        cpu_i = '0;
        step();
    endtask

    task automatic test_reset_mid_alloc();
        cpu_i.Valid = 1'b1;
        cpu_i.Write = 1'b0;
        cpu_i.Addr  = 32'h0001_0800;
        cpu_i.Wdata = '0;
        step();
        step();
        checks++;
        if (mem_i.Ready !== 1'b1 || mem_o.Valid !== 1'b1) begin
            errors++; $display("FAIL midrst_setup got mr%0b mv%0b want 1 1", mem_i.Ready, mem_o.Valid);
        end
        rst   = 1'b1;
        cpu_i = '0;
        step();
        rst = 1'b0;
        checks++;
        if (mem_o !== '0 || cpu_o.Ready !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got mem_o %h r%0b want 0 0", mem_o, cpu_o.Ready);
        end
        step();
        do_req(1'b0, 32'h0001_0800, '0, lat, rd);
        checks++;
        if (lat !== 5 || rd !== 32'h0BAD_0800) begin
            errors++; $display("FAIL midrst_refill got lat%0d d%h want lat5 d0bad0800", lat, rd);
        end
        step();
        do_req(1'b0, 32'h0001_0010, '0, lat, rd);
        checks++;
        if (lat !== 5 || rd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL midrst_cleared got lat%0d d%h want lat5 dcafef00d", lat, rd);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_eviction();
        test_write_miss();
        test_back_to_back();
        test_reset_mid_alloc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
